pio_fifo_pair: RTL and testbench
================================

# pio_fifo_pair

Per-state-machine data buffering between the host bus and one PIO state machine. TX FIFO: host writes, the machine pulls (`pull`/`din`/`empty`). RX FIFO: the machine pushes (`push`/`dout`/`full`), host reads. Both are first-word-fall-through, 4 deep, and can optionally be joined into a single 8-deep FIFO in one direction. Instantiated once per machine in the PIO top level.

## Interface
Parameters:
- `WIDTH`, 32: data word width.
- `DEPTH`, 4: entries per direction when unjoined. Fixed at 4; other values unsupported.

Ports:
- `clk`  input  1  system clock; one clock for the whole block.
- `reset`  input  1  asynchronous, active-high reset.
- `sm_step`  input  1  machine-side qualifier; drive with `en & penable`. `pull`/`push` act only when it is high.
- `pull`  input  1  machine pop request from the TX FIFO.
- `din`  output  WIDTH  TX head word; 0 when TX is empty.
- `empty`  output  1  TX FIFO empty, as seen by the machine.
- `push`  input  1  machine write request to the RX FIFO.
- `dout`  input  WIDTH  word pushed by the machine.
- `full`  output  1  RX FIFO full, as seen by the machine.
- `tx_wen`  input  1  host write strobe.
- `tx_wdata`  input  WIDTH  host write data.
- `tx_full`  output  1  TX full.
- `tx_level`  output  4  TX occupancy, 0..8.
- `rx_ren`  input  1  host read/pop strobe.
- `rx_rdata`  output  WIDTH  RX head word; 0 when RX is empty.
- `rx_empty`  output  1  RX empty.
- `rx_level`  output  4  RX occupancy, 0..8.
- `flags`  output  4  sticky flags: {tx_over, tx_under, rx_over, rx_under}.
- `flags_clr`  input  4  write-1-to-clear for `flags`, same bit order.
- `join_tx`, `join_rx`  input  1 each  join selects. Present only with `PIO_FIFO_JOIN_EN`.

## Operation
- Pop/push conditions:
  - TX pop = `sm_step & pull & !empty`.
  - RX push = `sm_step & push & !full`.
  - TX write = `tx_wen & !tx_full`.
  - RX read = `rx_ren & !rx_empty`.
- Full and empty are always evaluated on the pre-edge state:
  - A write into a full FIFO is dropped, even if a pop happens in the same cycle.
  - A pop from an empty FIFO does nothing, even if a write happens in the same cycle.
- Simultaneous write and pop on a non-empty, non-full FIFO: both happen, and the level is unchanged.
- Dropped or ignored accesses set sticky flags:
  - dropped host TX write → `tx_over`
  - qualified `pull` while empty → `tx_under` (the machine stalls; this flag is informational)
  - qualified `push` while full → `rx_over`
  - host read while empty → `rx_under`
- Flag clear versus set in the same cycle: the set wins.
- `din` and `rx_rdata` are combinational from the head entry, gated to 0 when empty.
- Pointers wrap modulo the active depth (4 or 8). The level counter is the source of truth for full and empty.

## Timing
- Reset values: levels 0, `empty`=1, `rx_empty`=1, `full`=0, `tx_full`=0, `flags`=0, `din`=0, `rx_rdata`=0. Storage is not reset.
- Write-to-visible latency is 1 cycle: a word written at edge N appears on the head output and clears `empty` after edge N.
- A pop at edge N presents the next head word after edge N.
- Status outputs are registered from the level and change only at clock edges.
- Reset asserted mid-operation empties both FIFOs immediately, asynchronously. Data in flight is lost.

## Configuration
- `PIO_FIFO_JOIN_EN` defined: `join_tx` and `join_rx` ports exist.
  - `join_tx`=1: TX becomes 8 deep. RX reports `full`=1, `rx_empty`=1, `rx_level`=0; pushes and reads on RX flag over/under as usual.
  - `join_rx`=1: the mirror case (RX 8 deep, TX permanently full and empty).
  - Both set: treated as no join.
  - Any change of the effective join mode flushes both FIFOs on the next edge; levels return to 0.
- Macro undefined: the ports are absent, depth is fixed at 4 per direction, and the join logic is removed.

## Structure
- Shared package `pio_pkg` holds:
  - the `FIFO_DEPTH`=4 and `FIFO_JOIN_DEPTH`=8 constants
  - flag bit index localparams (`FLAG_TX_OVER`=3 … `FLAG_RX_UNDER`=0)
- Storage is a single 8×WIDTH array. TX owns entries 0–3 and RX owns 4–7 when unjoined; the joined direction owns all 8.
- One sub-module, `fifo_ctrl`, is instantiated twice (once per direction). It contains the read/write pointers, level counter, full/empty and the depth-select input; the parent owns the array.

## Test plan
- Reset, then host writes 0xA, 0xB, 0xC → `tx_level`=3. Then `pull` with `sm_step`=1 for 3 cycles → `din` shows 0xA, 0xB, 0xC in order, then 0, and `empty`=1.
- `pull`=1 with `sm_step`=0 for 10 cycles with TX holding 2 words → no pop, `tx_level` stays 2.
- Fill TX with 4 words, then `tx_wen` together with a pop in the same cycle → write dropped, `tx_over` set, `tx_level`=3. Then `flags_clr`=4'b1000 → flag cleared.
- Machine pushes 5 words → first 4 stored, 5th dropped with `rx_over` set. Host reads 4 words in order; a 5th read returns 0 and sets `rx_under`.
- Empty TX, host write and qualified `pull` in the same cycle → no pop, `tx_under` set, `din` equals the written word on the next cycle.
- With `PIO_FIFO_JOIN_EN`: set `join_tx`=1 → both FIFOs flushed. 8 writes accepted, the 9th sets `tx_over`, and RX `full`=1 throughout. Clear `join_tx` → flush, `tx_level`=0.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants and types for the PIO FIFO pair.
package pio_pkg;

  localparam int FIFO_DEPTH      = 4;
  localparam int FIFO_JOIN_DEPTH = 8;

  // Bit positions inside the sticky flags vector.
  localparam int FLAG_TX_OVER  = 3;
  localparam int FLAG_TX_UNDER = 2;
  localparam int FLAG_RX_OVER  = 1;
  localparam int FLAG_RX_UNDER = 0;

  typedef enum logic [1:0] {
    JOIN_NONE = 2'd0,
    JOIN_TX   = 2'd1,
    JOIN_RX   = 2'd2
  } join_mode_e;

  // Both joins requested at once is treated the same as no join.
  function automatic join_mode_e join_mode(input logic jtx, input logic jrx);
    join_mode_e m;
    m = JOIN_NONE;
    if (jtx && !jrx) m = JOIN_TX;
    if (jrx && !jtx) m = JOIN_RX;
    return m;
  endfunction

endpackage

// File: rtl/pio_fifo_pair_fifo_ctrl.sv
// Pointer / level bookkeeping for one FIFO direction. The storage lives in
// the parent; this block only decides which accesses are accepted.
module fifo_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       deep,
  input  logic       disable_dir,
  input  logic       wr_req,
  input  logic       rd_req,
  output logic       wr_ok,
  output logic [2:0] wptr,
  output logic [2:0] rptr,
  output logic [3:0] level,
  output logic       full,
  output logic       empty
);
  import pio_pkg::*;

  logic [2:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic [3:0] level_d, level_q, depth;
  logic       full_d, full_q, empty_d, empty_q;
  logic       rd_ok;

  // Next pointers/level; full and empty are registered from the next level
  // so that accept decisions always use the pre-edge state.
  always_comb begin
    wr_ok   = wr_req & ~full_q;
    rd_ok   = rd_req & ~empty_q;
    depth   = deep ? 4'(FIFO_JOIN_DEPTH) : 4'(DEPTH);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (wr_ok) wptr_d = deep ? wptr_q + 3'd1 : {1'b0, wptr_q[1:0] + 2'd1};
    if (rd_ok) rptr_d = deep ? rptr_q + 3'd1 : {1'b0, rptr_q[1:0] + 2'd1};
    level_d = level_q + {3'b000, wr_ok} - {3'b000, rd_ok};
    if (flush || disable_dir) begin
      wptr_d  = 3'd0;
      rptr_d  = 3'd0;
      level_d = 4'd0;
    end
    full_d  = disable_dir | (level_d == depth);
    empty_d = (level_d == 4'd0);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= 3'd0;
      rptr_q  <= 3'd0;
      level_q <= 4'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign wptr  = wptr_q;
  assign rptr  = rptr_q;
  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair between host and one PIO state machine, first-word-fall-
// through, 4 deep each. Define PIO_FIFO_JOIN_EN to add join_tx/join_rx,
// which merge both halves into one 8-deep FIFO in a single direction.
module pio_fifo_pair
  import pio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sm_step,
  input  logic             pull,
  output logic [WIDTH-1:0] din,
  output logic             empty,
  input  logic             push,
  input  logic [WIDTH-1:0] dout,
  output logic             full,
  input  logic             tx_wen,
  input  logic [WIDTH-1:0] tx_wdata,
  output logic             tx_full,
  output logic [3:0]       tx_level,
  input  logic             rx_ren,
  output logic [WIDTH-1:0] rx_rdata,
  output logic             rx_empty,
  output logic [3:0]       rx_level,
  output logic [3:0]       flags,
  input  logic [3:0]       flags_clr
`ifdef PIO_FIFO_JOIN_EN
  ,
  input  logic             join_tx,
  input  logic             join_rx
`endif
);

  join_mode_e mode_d, mode_q;
  logic       flush;
  logic       tx_wr_ok, rx_wr_ok;
  logic [2:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [2:0] tx_waddr, tx_raddr, rx_waddr, rx_raddr;
  logic [3:0] flags_d, flags_q;
  logic [WIDTH-1:0] mem_q [FIFO_JOIN_DEPTH];

`ifdef PIO_FIFO_JOIN_EN
  // Effective join mode; a change of mode flushes both directions.
  always_comb mode_d = join_mode(join_tx, join_rx);

  // Remember the mode in force so a change can be detected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_q <= JOIN_NONE;
    else       mode_q <= mode_d;
  end
`else
  assign mode_d = JOIN_NONE;
  assign mode_q = JOIN_NONE;
`endif

  assign flush = (mode_d != mode_q);

  fifo_ctrl #(.DEPTH(DEPTH)) u_tx (
    .clk(clk), .reset(reset), .flush(flush),
    .deep(mode_d == JOIN_TX), .disable_dir(mode_d == JOIN_RX),
    .wr_req(tx_wen), .rd_req(sm_step & pull),
    .wr_ok(tx_wr_ok), .wptr(tx_wptr), .rptr(tx_rptr),
    .level(tx_level), .full(tx_full), .empty(empty)
  );

  fifo_ctrl #(.DEPTH(DEPTH)) u_rx (
    .clk(clk), .reset(reset), .flush(flush),
    .deep(mode_d == JOIN_RX), .disable_dir(mode_d == JOIN_TX),
    .wr_req(sm_step & push), .rd_req(rx_ren),
    .wr_ok(rx_wr_ok), .wptr(rx_wptr), .rptr(rx_rptr),
    .level(rx_level), .full(full), .empty(rx_empty)
  );

  // Array addressing: TX lives in 0-3 and RX in 4-7 unless joined.
  always_comb begin
    tx_waddr = (mode_q == JOIN_TX) ? tx_wptr : {1'b0, tx_wptr[1:0]};
    tx_raddr = (mode_q == JOIN_TX) ? tx_rptr : {1'b0, tx_rptr[1:0]};
    rx_waddr = (mode_q == JOIN_RX) ? rx_wptr : {1'b1, rx_wptr[1:0]};
    rx_raddr = (mode_q == JOIN_RX) ? rx_rptr : {1'b1, rx_rptr[1:0]};
    din      = empty    ? '0 : mem_q[tx_raddr];
    rx_rdata = rx_empty ? '0 : mem_q[rx_raddr];
  end

  // Storage, not reset. The two write ports never collide: a disabled
  // direction always reports full.
  always_ff @(posedge clk) begin
    if (tx_wr_ok) mem_q[tx_waddr] <= tx_wdata;
    if (rx_wr_ok) mem_q[rx_waddr] <= dout;
  end

  // Sticky flags; a set in the same cycle as its clear wins.
  always_comb begin
    flags_d = flags_q & ~flags_clr;
    if (tx_wen && tx_full)           flags_d[FLAG_TX_OVER]  = 1'b1;
    if (sm_step && pull && empty)    flags_d[FLAG_TX_UNDER] = 1'b1;
    if (sm_step && push && full)     flags_d[FLAG_RX_OVER]  = 1'b1;
    if (rx_ren && rx_empty)          flags_d[FLAG_RX_UNDER] = 1'b1;
  end

  // Flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'd0;
    else       flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_pio_fifo_pair.sv
module tb_pio_fifo_pair;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sm_step = 1'b0, pull = 1'b0, push = 1'b0;
  logic [W-1:0] din, dout = '0, tx_wdata = '0, rx_rdata;
  logic         empty, full, tx_wen = 1'b0, tx_full, rx_ren = 1'b0, rx_empty;
  logic [3:0]   tx_level, rx_level, flags, flags_clr = 4'd0;
`ifdef PIO_FIFO_JOIN_EN
  logic         join_tx = 1'b0, join_rx = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pio_fifo_pair #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .sm_step(sm_step), .pull(pull), .din(din),
    .empty(empty), .push(push), .dout(dout), .full(full), .tx_wen(tx_wen),
    .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_level(tx_level),
    .rx_ren(rx_ren), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
    .rx_level(rx_level), .flags(flags), .flags_clr(flags_clr)
`ifdef PIO_FIFO_JOIN_EN
    , .join_tx(join_tx), .join_rx(join_rx)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_flags", flags, 0);
    chk("rst_din", din, 0);
    chk("rst_rx_rdata", rx_rdata, 0);
    tick();
    reset = 1'b0;

    // host writes A,B,C then machine pulls three
    tx_wen = 1'b1;
    tx_wdata = 32'hA; tick();
    chk("lat1_din", din, 32'hA);
    chk("lat1_empty", empty, 0);
    tx_wdata = 32'hB; tick();
    tx_wdata = 32'hC; tick();
    tx_wen = 1'b0;
    chk("abc_level", tx_level, 3);
    chk("abc_head", din, 32'hA);
    sm_step = 1'b1; pull = 1'b1;
    tick(); chk("pop1_din", din, 32'hB);
    tick(); chk("pop2_din", din, 32'hC);
    tick(); chk("pop3_din", din, 0);
    pull = 1'b0;
    chk("pop3_empty", empty, 1);
    chk("pop3_level", tx_level, 0);
    chk("pop_flags", flags, 0);

    // pull without sm_step is ignored
    tx_wen = 1'b1;
    tx_wdata = 32'h11; tick();
    tx_wdata = 32'h22; tick();
    tx_wen = 1'b0;
    sm_step = 1'b0; pull = 1'b1;
    repeat (10) tick();
    chk("nostep_level", tx_level, 2);
    chk("nostep_din", din, 32'h11);
    sm_step = 1'b1;
    tick(); chk("nostep_pop", din, 32'h22);
    tick();
    pull = 1'b0;
    chk("drain_level", tx_level, 0);

    // full TX: write with simultaneous pop is dropped
    tx_wen = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tx_wdata = 32'(i); tick();
    end
    chk("fill_full", tx_full, 1);
    chk("fill_level", tx_level, 4);
    tx_wdata = 32'h55; pull = 1'b1;
    tick();
    tx_wen = 1'b0; pull = 1'b0;
    chk("ovr_level", tx_level, 3);
    chk("ovr_flag", flags, 4'b1000);
    chk("ovr_din", din, 2);
    chk("ovr_notfull", tx_full, 0);
    flags_clr = 4'b1000; tick(); flags_clr = 4'd0;
    chk("ovr_clr", flags, 0);
    pull = 1'b1;
    tick(); chk("wrap_din3", din, 3);
    tick(); chk("wrap_din4", din, 4);
    tick(); pull = 1'b0;
    chk("wrap_empty", empty, 1);

    // RX: 5 pushes, 4 stored, then 5 reads
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dout = 32'h100 + 32'(i); tick();
    end
    push = 1'b0;
    chk("rx_full", full, 1);
    chk("rx_level4", rx_level, 4);
    chk("rx_over", flags, 4'b0010);
    rx_ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rx_read", rx_rdata, 32'h100 + 32'(i));
      tick();
    end
    chk("rx_drained", rx_empty, 1);
    chk("rx_zero", rx_rdata, 0);
    tick();
    rx_ren = 1'b0;
    chk("rx_under", flags, 4'b0011);
    chk("rx_under_data", rx_rdata, 0);
    // clear versus set in the same cycle: set wins
    rx_ren = 1'b1; flags_clr = 4'b0011; tick();
    rx_ren = 1'b0; flags_clr = 4'd0;
    chk("clr_vs_set", flags, 4'b0001);
    flags_clr = 4'b0001; tick(); flags_clr = 4'd0;
    chk("clr_all", flags, 0);

    // empty TX: write and qualified pull in the same cycle
    tx_wen = 1'b1; tx_wdata = 32'h77; pull = 1'b1;
    tick();
    tx_wen = 1'b0; pull = 1'b0;
    chk("wp_level", tx_level, 1);
    chk("wp_din", din, 32'h77);
    chk("wp_under", flags, 4'b0100);

    // asynchronous reset mid-operation
    #2 reset = 1'b1;
    #1;
    chk("arst_level", tx_level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_din", din, 0);
    chk("arst_flags", flags, 0);
    tick();
    reset = 1'b0;

`ifdef PIO_FIFO_JOIN_EN
    tx_wen = 1'b1; tx_wdata = 32'h9; tick(); tx_wen = 1'b0;
    join_tx = 1'b1; tick();
    chk("join_flush", tx_level, 0);
    chk("join_rx_full", full, 1);
    tx_wen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_wdata = 32'h200 + 32'(i); tick();
      chk("join_rx_full_t", full, 1);
      chk("join_rx_empty", rx_empty, 1);
    end
    chk("join_level8", tx_level, 8);
    chk("join_flags0", flags, 0);
    tx_wdata = 32'h2FF; tick();
    tx_wen = 1'b0;
    chk("join_over", flags, 4'b1000);
    chk("join_level_hold", tx_level, 8);
    chk("join_head", din, 32'h200);
    join_tx = 1'b0; tick();
    chk("unjoin_flush", tx_level, 0);
    chk("unjoin_rx_full", full, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
